// File: rtl/irq_pkg.sv
// Shared constants and helpers for the interrupt request-capture stage.
// Bus codes and the (bus, chan) -> line index mapping live here.
package irq_pkg;

    localparam int NCH   = 9;
    localparam int NBUS  = 3;
    localparam int NLINE = NBUS * NCH;

    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_A    = 2'd1;
    localparam logic [1:0] BUS_B    = 2'd2;
    localparam logic [1:0] BUS_C    = 2'd3;

    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
    } line_t;

    function automatic line_t line_of(input logic [1:0] bus,
                                      input logic [3:0] chan);
        line_t r;
        r.valid = 1'b0;
        r.idx   = '0;
        if (bus != BUS_NONE && chan < 4'(NCH)) begin
            r.valid = 1'b1;
            r.idx   = 5'(bus - 2'd1) * 5'(NCH) + 5'(chan);
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_line_cell.sv
// One interrupt line: mode, previous raw sample, pending and overflow state.
// pend_nxt is exported so the top can register any_pend in step with req.
module irq_line_cell
    import irq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic mode_wr,
    input  logic mode_d,
    input  logic ack_hit,
    input  logic ovf_clr,
    output logic pend,
    output logic pend_nxt,
    output logic ovf
);

    logic mode;
    logic prev;
    logic rise;
    logic ovf_set;

    assign rise    = raw & ~prev;
    assign ovf_set = mode & rise & pend & ~ack_hit;

    always_comb begin
        pend_nxt = raw;
        if (mode) begin
            pend_nxt = rise | (pend & ~ack_hit);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode <= 1'b0;
            prev <= 1'b0;
            pend <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            prev <= raw;
            pend <= pend_nxt;
            if (mode_wr) begin
                mode <= mode_d;
            end
            // a fresh overflow outranks a coincident clear
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/irq_request_capture.sv
// Request-capture stage: 27 line cells, enable register, ack decode
// and the registered any_pend summary for the priority resolver.
module irq_request_capture
    import irq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [NLINE-1:0]  irq_raw,
    input  logic              mode_wr,
    input  logic [NLINE-1:0]  mode_data,
    input  logic              en_wr,
    input  logic [NCH-1:0]    en_data,
    input  logic              ack_valid,
    input  logic [1:0]        ack_bus,
    input  logic [3:0]        ack_chan,
    input  logic              ovf_clr,
    output logic [NCH-1:0]    req_a,
    output logic [NCH-1:0]    req_b,
    output logic [NCH-1:0]    req_c,
    output logic [NCH-1:0]    en,
    output logic              any_pend,
    output logic [NLINE-1:0]  ovf
);

    line_t            hit;
    logic [NLINE-1:0] ack_hit;
    logic [NLINE-1:0] pend;
    logic [NLINE-1:0] pend_nxt;
    logic [NCH-1:0]   en_nxt;

    assign hit = line_of(ack_bus, ack_chan);

    always_comb begin
        ack_hit = '0;
        if (ack_valid && hit.valid) begin
            ack_hit[hit.idx] = 1'b1;
        end
    end

    for (genvar i = 0; i < NLINE; i++) begin : g_line
        irq_line_cell u_cell (
            .clk      (clk),
            .rst      (rst),
            .raw      (irq_raw[i]),
            .mode_wr  (mode_wr),
            .mode_d   (mode_data[i]),
            .ack_hit  (ack_hit[i]),
            .ovf_clr  (ovf_clr),
            .pend     (pend[i]),
            .pend_nxt (pend_nxt[i]),
            .ovf      (ovf[i])
        );
    end

    assign req_a  = pend[NCH-1:0];
    assign req_b  = pend[2*NCH-1:NCH];
    assign req_c  = pend[3*NCH-1:2*NCH];
    assign en_nxt = en_wr ? en_data : en;

    always_ff @(posedge clk) begin
        if (rst) begin
            en       <= '0;
            any_pend <= 1'b0;
        end else begin
            en       <= en_nxt;
            any_pend <= |(pend_nxt & {NBUS{en_nxt}});
        end
    end

endmodule

// File: tb/tb_irq_request_capture.sv
// Directed test of irq_request_capture with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_irq_request_capture;
    import irq_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [NLINE-1:0]  irq_raw;
    logic              mode_wr;
    logic [NLINE-1:0]  mode_data;
    logic              en_wr;
    logic [NCH-1:0]    en_data;
    logic              ack_valid;
    logic [1:0]        ack_bus;
    logic [3:0]        ack_chan;
    logic              ovf_clr;
    logic [NCH-1:0]    req_a;
    logic [NCH-1:0]    req_b;
    logic [NCH-1:0]    req_c;
    logic [NCH-1:0]    en;
    logic              any_pend;
    logic [NLINE-1:0]  ovf;

    int total = 0;
    int bad   = 0;

    irq_request_capture dut (
        .clk       (clk),
        .rst       (rst),
        .irq_raw   (irq_raw),
        .mode_wr   (mode_wr),
        .mode_data (mode_data),
        .en_wr     (en_wr),
        .en_data   (en_data),
        .ack_valid (ack_valid),
        .ack_bus   (ack_bus),
        .ack_chan  (ack_chan),
        .ovf_clr   (ovf_clr),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .en        (en),
        .any_pend  (any_pend),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // one clock; single-cycle strobes drop afterwards
    task automatic step();
        @(posedge clk);
        #1;
        mode_wr   = 1'b0;
        en_wr     = 1'b0;
        ack_valid = 1'b0;
        ovf_clr   = 1'b0;
    endtask

    task automatic ack(input logic [1:0] b, input logic [3:0] c);
        ack_valid = 1'b1;
        ack_bus   = b;
        ack_chan  = c;
    endtask

    initial begin
        rst       = 1'b1;
        irq_raw   = '1;
        mode_wr   = 1'b0;
        mode_data = '0;
        en_wr     = 1'b0;
        en_data   = '0;
        ack_valid = 1'b0;
        ack_bus   = '0;
        ack_chan  = '0;
        ovf_clr   = 1'b0;
        #1;
        step();
        step();
        check("rst_req_a", 32'(req_a), 32'h0);
        check("rst_req_b", 32'(req_b), 32'h0);
        check("rst_req_c", 32'(req_c), 32'h0);
        check("rst_en", 32'(en), 32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);
        check("rst_any", 32'(any_pend), 32'h0);

        rst = 1'b0;
        step();
        check("lvl_req_a", 32'(req_a), 32'h1FF);
        check("lvl_any_masked", 32'(any_pend), 32'h0);

        // edge mode everywhere, all channels enabled
        irq_raw   = '0;
        mode_wr   = 1'b1;
        mode_data = '1;
        en_wr     = 1'b1;
        en_data   = 9'h1FF;
        step();
        check("en_all", 32'(en), 32'h1FF);
        check("idle_req_b", 32'(req_b), 32'h0);
        irq_raw[12] = 1'b1;
        step();
        check("edge_req_b", 32'(req_b), 32'h008);
        check("edge_any", 32'(any_pend), 32'h1);
        irq_raw = '0;
        step();
        check("edge_hold", 32'(req_b), 32'h008);
        ack(BUS_B, 4'd3);
        step();
        check("ack_clr_b", 32'(req_b), 32'h0);
        check("ack_any", 32'(any_pend), 32'h0);

        // rise and ack on the same bit in one cycle
        irq_raw[12] = 1'b1;
        step();
        irq_raw = '0;
        step();
        irq_raw[12] = 1'b1;
        ack(BUS_B, 4'd3);
        step();
        check("setwin_req_b", 32'(req_b), 32'h008);
        check("setwin_ovf", 32'(ovf), 32'h0);
        irq_raw = '0;
        ack(BUS_B, 4'd3);
        step();

        // overflow on C ch8
        irq_raw[26] = 1'b1;
        step();
        check("c8_req_c", 32'(req_c), 32'h100);
        irq_raw = '0;
        step();
        irq_raw[26] = 1'b1;
        step();
        check("ovf_set", 32'(ovf), 32'h400_0000);
        irq_raw = '0;
        ovf_clr = 1'b1;
        step();
        check("ovf_clr", 32'(ovf), 32'h0);
        check("ovf_pend_kept", 32'(req_c), 32'h100);
        irq_raw[26] = 1'b1;
        ovf_clr     = 1'b1;
        step();
        check("ovf_clr_race", 32'(ovf), 32'h400_0000);
        irq_raw = '0;
        ovf_clr = 1'b1;
        ack(BUS_C, 4'd8);
        step();
        check("c8_acked", 32'(req_c), 32'h0);
        check("ovf_clr2", 32'(ovf), 32'h0);

        // invalid acks are ignored
        irq_raw[0]  = 1'b1;
        irq_raw[9]  = 1'b1;
        irq_raw[26] = 1'b1;
        step();
        irq_raw = '0;
        ack(BUS_NONE, 4'd0);
        step();
        check("bad0_req_a", 32'(req_a), 32'h001);
        check("bad0_req_c", 32'(req_c), 32'h100);
        ack(BUS_C, 4'd9);
        step();
        check("bad9_req_c", 32'(req_c), 32'h100);
        ack(BUS_A, 4'd9);
        step();
        check("a9_req_b", 32'(req_b), 32'h001);
        ack(BUS_A, 4'd0);
        step();
        check("a0_req_a", 32'(req_a), 32'h0);
        check("a0_req_c", 32'(req_c), 32'h100);
        check("a0_req_b", 32'(req_b), 32'h001);

        // level mode with masking; mode and enable written together
        mode_wr   = 1'b1;
        mode_data = '0;
        en_wr     = 1'b1;
        en_data   = 9'h000;
        step();
        check("old_mode_used", 32'(req_c), 32'h100);
        irq_raw[5] = 1'b1;
        step();
        check("lvl5_req_a", 32'(req_a), 32'h020);
        check("lvl_req_c", 32'(req_c), 32'h0);
        check("lvl5_masked", 32'(any_pend), 32'h0);
        en_wr   = 1'b1;
        en_data = 9'h020;
        step();
        check("lvl5_any", 32'(any_pend), 32'h1);
        check("lvl5_en", 32'(en), 32'h020);
        ack(BUS_A, 4'd5);
        step();
        check("lvl_ack_noeff", 32'(req_a), 32'h020);
        irq_raw = '0;
        ack(BUS_A, 4'd5);
        step();
        check("lvl_drop", 32'(req_a), 32'h0);
        check("lvl_drop_any", 32'(any_pend), 32'h0);
        ack(BUS_A, 4'd5);
        step();
        check("lvl_ack_idle", 32'(req_a), 32'h0);
        check("lvl_no_ovf", 32'(ovf), 32'h0);

        // level->edge switch keeps pending, no spurious edge from a high line
        irq_raw[5] = 1'b1;
        step();
        mode_wr   = 1'b1;
        mode_data = '1;
        step();
        step();
        check("switch_keep", 32'(req_a), 32'h020);
        ack(BUS_A, 4'd5);
        step();
        check("switch_noedge", 32'(req_a), 32'h0);

        // reset mid-operation drops everything
        irq_raw[7] = 1'b0;
        step();
        irq_raw[7] = 1'b1;
        step();
        check("pre_rst_req_a", 32'(req_a), 32'h080);
        rst = 1'b1;
        ack(BUS_A, 4'd7);
        step();
        check("rst2_req_a", 32'(req_a), 32'h0);
        check("rst2_en", 32'(en), 32'h0);
        check("rst2_any", 32'(any_pend), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_request_capture.md
Name: irq_request_capture

Overview:
- Request-capture stage feeding the 27-channel combinational interrupt priority resolver: three 9-bit request buses A/B/C plus a shared 9-bit enable vector.
- Samples raw interrupt lines, applies per-line edge or level mode, and holds pending bits until the downstream dispatcher acknowledges the granted bus/channel.
- Holds the channel-enable register.
- Reports overflow: a new edge arriving while that line is already pending.

Parameters:
- NCH, 9, channels per bus; one enable bit per channel position.
- NBUS, 3, number of request buses (A=0, B=1, C=2); total lines = NBUS*NCH = 27.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous active-high reset
- irq_raw  in  27  raw request lines, already synchronous to clk; bits [8:0]=A, [17:9]=B, [26:18]=C
- mode_wr  in  1  load mode register this cycle
- mode_data  in  27  per-line mode, 1=rising-edge, 0=level
- en_wr  in  1  load enable register this cycle
- en_data  in  9  channel enables
- ack_valid  in  1  dispatcher acknowledges one line this cycle
- ack_bus  in  2  1=A, 2=B, 3=C, 0=invalid
- ack_chan  in  4  channel index 0..8
- ovf_clr  in  1  clear all overflow flags
- req_a  out  9  pending A lines to resolver
- req_b  out  9  pending B lines
- req_c  out  9  pending C lines
- en  out  9  enable vector to resolver
- any_pend  out  1  OR over (pending AND enable broadcast to all buses)
- ovf  out  27  sticky overflow flags

Behaviour:
- Reset (sync, rst=1 at clk edge): pending=0, prev_raw=0, mode=0 (all level), en=0 (all masked), ovf=0, hence req_*=0 and any_pend=0. Reset dominates every other input in the same cycle; pending state is dropped mid-operation.
- All outputs are registered; each req bit reflects pending state after the edge. Latency from irq_raw to req is 1 cycle.
- prev_raw <= irq_raw every cycle.
- Level line (mode=0):
  - pending <= irq_raw.
  - ack on a level line has no effect; the source must drop the line.
  - ovf never sets.
- Edge line (mode=1):
  - rise = irq_raw & ~prev_raw.
  - pending_next = rise | (pending & ~ack_hit).
  - Simultaneous rise and ack on the same bit: set wins, pending stays 1.
  - ovf sets when rise & pending & ~ack_hit.
- ack_hit decode:
  - Hits exactly bit (ack_bus-1)*9 + ack_chan when ack_valid=1, ack_bus != 0 and ack_chan <= 8.
  - Otherwise it is ignored: no bit cleared, no error.
- Mode change (mode_wr):
  - New mode applies to the next cycle's update.
  - A line switching level->edge keeps its current pending value.
  - prev_raw is not reset, so a line that is already high does not produce a spurious edge.
- en_wr: en <= en_data. It does not alter pending; masking is done by the resolver and by any_pend.
- Writing mode_wr and en_wr in the same cycle is legal; both take effect.
- ovf clearing:
  - ovf_clr clears all ovf bits.
  - A new overflow in the same cycle as ovf_clr wins, and that bit stays set.
- any_pend is registered and computed from the next-state pending and en, so it is aligned with req_*.
- Resolver output polarity and encoding are owned by the resolver. This block's contract is active-high request and enable.

Decomposition:
- Shared package irq_pkg: NCH, NBUS, NLINE=27, bus code constants BUS_NONE=0/BUS_A=1/BUS_B=2/BUS_C=3, and a function mapping (bus, chan) to line index with validity.
- One natural sub-module: irq_line_cell. It holds pending, prev_raw, mode and ovf for a single line and is instantiated 27 times. The top holds the enable register, ack decode, bus slicing and any_pend.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with irq_raw=all-ones -> req_a/b/c=0, en=0, ovf=0, any_pend=0. After release with mode=0, req_a=0x1FF one cycle later; any_pend=0 because en=0.
- Edge capture and ack: mode=all-ones, en=0x1FF, pulse irq_raw[12] (B ch3) for 1 cycle -> req_b=0x008 and any_pend=1, held while the line is low. Then ack_valid, ack_bus=2, ack_chan=3 -> req_b=0x000 next cycle.
- Set-wins collision: B ch3 pending; in one cycle raise a new edge on bit 12 and ack it -> req_b stays 0x008, ovf[12]=0.
- Overflow: C ch8 pending, second rising edge on bit 26 with no ack -> ovf[26]=1. ovf_clr -> 0. ovf_clr coincident with a further overflow -> ovf[26] stays 1.
- Invalid ack: A ch0 and C ch8 pending; ack_bus=0 chan=0, then ack_bus=3 chan=9 -> no pending bit changes. ack_bus=1 chan=0 -> req_a=0x000, req_c unchanged (0x100).
- Level mode and mask: mode=0, irq_raw[5]=1, en=0x000 -> req_a=0x020, any_pend=0. en_wr with 0x020 -> any_pend=1 next cycle. Drop irq_raw[5] -> req_a=0 next cycle, and an ack leaves it unaffected.
